// File: rtl/load_store_buffer.sv
// In-order load/store queue: tracks operand tags, snoops RS and load broadcasts,
// and issues one memory access at a time from the head.
module load_store_buffer #(
    parameter int unsigned LSB_WIDTH = 3,
    parameter int unsigned ROB_WIDTH = 4
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 clear,
    input  logic                 addFlag,
    input  logic                 addStore,
    input  logic [2:0]           addFunct3,
    input  logic [ROB_WIDTH-1:0] addRobId,
    input  logic                 addBaseBusy,
    input  logic [ROB_WIDTH-1:0] addBaseId,
    input  logic [31:0]          addBaseVal,
    input  logic [31:0]          addOffset,
    input  logic                 addDataBusy,
    input  logic [ROB_WIDTH-1:0] addDataId,
    input  logic [31:0]          addDataVal,
    output logic                 full,
    input  logic                 rsFlag,
    input  logic [ROB_WIDTH-1:0] rsId,
    input  logic [31:0]          rsValue,
    input  logic                 storeFlag,
    input  logic [ROB_WIDTH-1:0] storeId,
    output logic                 loadFlag,
    output logic [ROB_WIDTH-1:0] loadId,
    output logic [31:0]          loadValue,
    output logic                 memReqFlag,
    output logic                 memWrite,
    output logic [31:0]          memAddr,
    output logic [1:0]           memLen,
    output logic [31:0]          memWData,
    input  logic                 memDone,
    input  logic [31:0]          memRData
);

    localparam int unsigned LSB_SIZE = 1 << LSB_WIDTH;
    localparam int unsigned CNT_W    = LSB_WIDTH + 1;

    typedef struct packed {
        logic                 valid;
        logic                 store;
        logic                 committed;
        logic [2:0]           funct3;
        logic [ROB_WIDTH-1:0] rob_id;
        logic                 base_busy;
        logic [ROB_WIDTH-1:0] base_id;
        logic [31:0]          base_val;
        logic [31:0]          offset;
        logic                 data_busy;
        logic [ROB_WIDTH-1:0] data_id;
        logic [31:0]          data_val;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    entry_t               ent_q [LSB_SIZE];
    entry_t               ent_d [LSB_SIZE];
    entry_t               new_e;
    logic [LSB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d, cc_q, cc_d;
    logic                 load_flag_q, load_flag_d;
    logic [ROB_WIDTH-1:0] load_id_q, load_id_d;
    logic [31:0]          load_value_q, load_value_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_write_q, mem_write_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [1:0]           mem_len_q, mem_len_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic                 head_ready;
    logic                 commit_hit;
    logic [32:0]          snp;

    // Returns {busy, value} after matching a pending operand against both broadcasts.
    function automatic logic [32:0] snoop_op(
        input logic                 busy,
        input logic [ROB_WIDTH-1:0] id,
        input logic [31:0]          val,
        input logic                 rs_f,
        input logic [ROB_WIDTH-1:0] rs_id,
        input logic [31:0]          rs_val,
        input logic                 ld_f,
        input logic [ROB_WIDTH-1:0] ld_id,
        input logic [31:0]          ld_val
    );
        logic [32:0] r;
        r = {busy, val};
        if (busy && rs_f && (rs_id == id)) begin
            r = {1'b0, rs_val};
        end else if (busy && ld_f && (ld_id == id)) begin
            r = {1'b0, ld_val};
        end
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{raw[7]}}, raw[7:0]};
            3'b001:  r = {{16{raw[15]}}, raw[15:0]};
            3'b100:  r = {24'd0, raw[7:0]};
            3'b101:  r = {16'd0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    assign full       = (count_q == CNT_W'(LSB_SIZE));
    assign loadFlag   = load_flag_q;
    assign loadId     = load_id_q;
    assign loadValue  = load_value_q;
    assign memReqFlag = mem_req_q;
    assign memWrite   = mem_write_q;
    assign memAddr    = mem_addr_q;
    assign memLen     = mem_len_q;
    assign memWData   = mem_wdata_q;

    // Head is issuable once its base is ready; stores also need data and commit.
    always_comb begin
        head_ready = ent_q[head_q].valid && !ent_q[head_q].base_busy &&
                     (!ent_q[head_q].store ||
                      (!ent_q[head_q].data_busy && ent_q[head_q].committed));
    end

    // Next-state logic: snoop, commit, FSM pop, enqueue, then flush overrides.
    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        cc_d         = cc_q;
        ent_d        = ent_q;
        load_flag_d  = load_flag_q;
        load_id_d    = load_id_q;
        load_value_d = load_value_q;
        mem_req_d    = mem_req_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_len_d    = mem_len_q;
        mem_wdata_d  = mem_wdata_q;
        commit_hit   = 1'b0;
        snp          = '0;
        new_e        = '0;

        if (readyIn) begin
            load_flag_d = 1'b0;

            for (int i = 0; i < int'(LSB_SIZE); i++) begin
                if (ent_q[i].valid) begin
                    snp = snoop_op(ent_q[i].base_busy, ent_q[i].base_id, ent_q[i].base_val,
                                   rsFlag, rsId, rsValue, load_flag_q, load_id_q, load_value_q);
                    ent_d[i].base_busy = snp[32];
                    ent_d[i].base_val  = snp[31:0];
                    snp = snoop_op(ent_q[i].data_busy, ent_q[i].data_id, ent_q[i].data_val,
                                   rsFlag, rsId, rsValue, load_flag_q, load_id_q, load_value_q);
                    ent_d[i].data_busy = snp[32];
                    ent_d[i].data_val  = snp[31:0];
                end
            end

            if (storeFlag) begin
                for (int i = 0; i < int'(LSB_SIZE); i++) begin
                    if (!commit_hit && ent_q[i].valid && ent_q[i].store &&
                        !ent_q[i].committed && (ent_q[i].rob_id == storeId)) begin
                        ent_d[i].committed = 1'b1;
                        commit_hit         = 1'b1;
                    end
                end
                if (commit_hit) begin
                    cc_d = cc_d + 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (head_ready) begin
                        mem_req_d   = 1'b1;
                        mem_write_d = ent_q[head_q].store;
                        mem_addr_d  = ent_q[head_q].base_val + ent_q[head_q].offset;
                        mem_len_d   = ent_q[head_q].funct3[1:0];
                        mem_wdata_d = ent_q[head_q].data_val;
                        state_d     = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (memDone) begin
                        mem_req_d            = 1'b0;
                        ent_d[head_q].valid  = 1'b0;
                        head_d               = head_q + 1'b1;
                        count_d              = count_d - 1'b1;
                        if (ent_q[head_q].store) begin
                            cc_d = cc_d - 1'b1;
                        end else begin
                            load_flag_d  = 1'b1;
                            load_id_d    = ent_q[head_q].rob_id;
                            load_value_d = extend_load(ent_q[head_q].funct3, memRData);
                        end
                        state_d = S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (memDone) begin
                        mem_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (addFlag && !full && !clear) begin
                new_e.valid     = 1'b1;
                new_e.store     = addStore;
                new_e.funct3    = addFunct3;
                new_e.rob_id    = addRobId;
                new_e.base_id   = addBaseId;
                new_e.offset    = addOffset;
                new_e.data_id   = addDataId;
                snp = snoop_op(addBaseBusy, addBaseId, addBaseVal,
                               rsFlag, rsId, rsValue, load_flag_q, load_id_q, load_value_q);
                new_e.base_busy = snp[32];
                new_e.base_val  = snp[31:0];
                snp = snoop_op(addDataBusy, addDataId, addDataVal,
                               rsFlag, rsId, rsValue, load_flag_q, load_id_q, load_value_q);
                new_e.data_busy = snp[32];
                new_e.data_val  = snp[31:0];
                ent_d[tail_q]   = new_e;
                tail_d          = tail_q + 1'b1;
                count_d         = count_d + 1'b1;
            end

            // Committed stores sit contiguously at the head, so the survivors end at head+cc.
            if (clear) begin
                for (int i = 0; i < int'(LSB_SIZE); i++) begin
                    if (!ent_d[i].committed) begin
                        ent_d[i].valid = 1'b0;
                    end
                end
                tail_d      = head_d + LSB_WIDTH'(cc_d);
                count_d     = cc_d;
                load_flag_d = 1'b0;
                if ((state_d == S_WAIT) && !ent_q[head_q].store) begin
                    state_d = S_DISCARD;
                end
            end
        end
    end

    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            state_q      <= S_IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            cc_q         <= '0;
            load_flag_q  <= 1'b0;
            load_id_q    <= '0;
            load_value_q <= '0;
            mem_req_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_len_q    <= '0;
            mem_wdata_q  <= '0;
            for (int i = 0; i < int'(LSB_SIZE); i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            cc_q         <= cc_d;
            load_flag_q  <= load_flag_d;
            load_id_q    <= load_id_d;
            load_value_q <= load_value_d;
            mem_req_q    <= mem_req_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_len_q    <= mem_len_d;
            mem_wdata_q  <= mem_wdata_d;
            for (int i = 0; i < int'(LSB_SIZE); i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule
